coin_acceptor: RTL and testbench



---
 rtl/coin_acceptor.sv | 156 +++++++++++++++
 tb/tb_coin_acceptor.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin acceptor: per-sensor synchronizer/debouncer, coin FIFO and paced money emitter
// feeding the vending-machine FSM. Channel 0 is the nickel sensor, channel 1 the dime sensor.

module coin_acceptor_chan #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic event_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1_q, s2_q, filt_q, filt_dly_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_q       <= raw_i;
            s2_q       <= s1_q;
            filt_dly_q <= filt_q;
            // Any sample matching the filtered level restarts the stability count.
            if (s2_q != filt_q) begin
                if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    filt_q <= s2_q;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign event_o = filt_q & ~filt_dly_q;
endmodule

module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               nickel_in,
    input  logic                               dime_in,
    input  logic                               hold,
    output logic [1:0]                         money,
    output logic                               coin_reject,
    output logic                               fifo_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    pending
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int GW   = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    logic [1:0] raw, ev;
    assign raw = {dime_in, nickel_in};

    genvar ch;
    generate
        for (ch = 0; ch < 2; ch++) begin : g_chan
            coin_acceptor_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
                .clk     (clk),
                .rst     (rst),
                .raw_i   (raw[ch]),
                .event_o (ev[ch])
            );
        end
    endgenerate

    logic [FIFO_DEPTH-1:0][1:0] mem_q;
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]            count_q, count_d;
    state_t                     state_q, state_d;
    logic [GW-1:0]              gap_q, gap_d;
    logic [1:0]                 money_q, money_d;
    logic                       reject_q, reject_d, full_q, full_d;
    logic                       pop, push, gap_last, launch_ok;
    logic [1:0]                 push_code;

    assign gap_last  = (state_q == GAP) && (gap_q == GW'(GAP_CYCLES - 1));
    // The final GAP cycle doubles as the IDLE decision point so a waiting coin
    // follows after exactly GAP_CYCLES zero cycles.
    assign launch_ok = (state_q == IDLE) || gap_last;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        money_d = 2'b00;
        pop     = 1'b0;
        case (state_q)
            SEND: begin
                state_d = GAP;
                gap_d   = '0;
            end
            GAP: begin
                if (gap_last) state_d = IDLE;
                else          gap_d   = gap_q + GW'(1);
            end
            default: ;
        endcase
        if (launch_ok && count_q != '0 && !hold) begin
            pop     = 1'b1;
            money_d = mem_q[rd_ptr_q];
            state_d = SEND;
        end
    end

    // A lone event may push when there is room, or when full but popping this edge.
    assign push      = (^ev) && ((count_q != CNTW'(FIFO_DEPTH)) || pop);
    assign push_code = ev[0] ? 2'b01 : 2'b10;
    assign reject_d  = (&ev) | ((^ev) & ~push);
    assign count_d   = count_q + CNTW'(push) - CNTW'(pop);
    assign full_d    = (count_d == CNTW'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            gap_q    <= '0;
            money_q  <= 2'b00;
            reject_q <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q  <= count_d;
            state_q  <= state_d;
            gap_q    <= gap_d;
            money_q  <= money_d;
            reject_q <= reject_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= push_code;
    end

    assign money       = money_q;
    assign coin_reject = reject_q;
    assign fifo_full   = full_q;
    assign pending     = count_q;
endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus random sensor/hold traffic
// checked cycle by cycle against a coin-level reference model.

module tb_coin_acceptor;
    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int G     = 2;
    localparam int PW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0, rst = 1'b1, nickel_in = 1'b0, dime_in = 1'b0, hold = 1'b0;
    logic [1:0]    money;
    logic          coin_reject, fifo_full;
    logic [PW-1:0] pending;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    coin_acceptor #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(G)) dut (
        .clk         (clk),
        .rst         (rst),
        .nickel_in   (nickel_in),
        .dime_in     (dime_in),
        .hold        (hold),
        .money       (money),
        .coin_reject (coin_reject),
        .fifo_full   (fifo_full),
        .pending     (pending)
    );

    // Reference model: a sensor held high for D samples becomes a coin pushed 3 edges
    // later; coins leave oldest-first, at most one per 1+G edges, only while hold is low.
    int            e = 0, last_emit = -1000;
    int            mq[$], sq_n[$], sq_d[$];
    int            hi_n = 0, hi_d = 0, lo_n = 0, lo_d = 0;
    bit            arm_n = 1, arm_d = 1, ev_n, ev_d;
    logic [1:0]    exp_money = 0;
    logic          exp_rej = 0, exp_full = 0;
    logic [PW-1:0] exp_pend = 0;

    task automatic model_step();
        e++;
        if (rst) begin
            mq.delete(); sq_n.delete(); sq_d.delete();
            hi_n = 0; hi_d = 0; lo_n = 0; lo_d = 0; arm_n = 1; arm_d = 1;
            last_emit = -1000;
            exp_money = 0; exp_rej = 0; exp_full = 0; exp_pend = 0;
        end else begin
            ev_n = (sq_n.size() > 0) && (sq_n[0] == e);
            ev_d = (sq_d.size() > 0) && (sq_d[0] == e);
            if (ev_n) void'(sq_n.pop_front());
            if (ev_d) void'(sq_d.pop_front());
            exp_money = 0;
            exp_rej   = 0;
            if (mq.size() > 0 && !hold && (e - last_emit) >= 1 + G) begin
                exp_money = 2'(mq.pop_front());
                last_emit = e;
            end
            if (ev_n && ev_d) exp_rej = 1;
            else if (ev_n || ev_d) begin
                if (mq.size() < DEPTH) mq.push_back(ev_n ? 1 : 2);
                else exp_rej = 1;
            end
            exp_pend = PW'(mq.size());
            exp_full = (mq.size() == DEPTH);
            if (nickel_in) begin
                hi_n++; lo_n = 0;
                if (hi_n == D && arm_n) begin sq_n.push_back(e + 3); arm_n = 0; end
            end else begin
                hi_n = 0; lo_n++;
                if (lo_n >= D) arm_n = 1;
            end
            if (dime_in) begin
                hi_d++; lo_d = 0;
                if (hi_d == D && arm_d) begin sq_d.push_back(e + 3); arm_d = 0; end
            end else begin
                hi_d = 0; lo_d++;
                if (lo_d >= D) arm_d = 1;
            end
        end
    endtask

    always @(posedge clk) model_step();

    int rej_seen = 0, emit_seen = 0;
    always @(negedge clk) begin
        if (coin_reject)    rej_seen  <= rej_seen + 1;
        if (money != 2'b00) emit_seen <= emit_seen + 1;
    end

    task automatic pulse(input logic [1:0] m, input int len, input int gap);
        @(negedge clk);
        nickel_in = m[0];
        dime_in   = m[1];
        repeat (len) @(negedge clk);
        nickel_in = 1'b0;
        dime_in   = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (money !== 2'b00) begin errors++; $display("FAIL reset_money: got %0d expected 0", money); end
        checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL reset_reject: got %0b expected 0", coin_reject); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", fifo_full); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending: got %0d expected 0", pending); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nickel();
        int k, hits = 0, hit_e = -1, code = 0;
        @(negedge clk);
        nickel_in = 1'b1;
        k = e + 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (money !== 2'b00) begin hits++; hit_e = e; code = int'(money); end
            if (i == 7) nickel_in = 1'b0;
        end
        checks++; if (hits != 1) begin errors++; $display("FAIL nickel_count: got %0d codes expected 1", hits); end
        checks++; if (hit_e != k + D + 3) begin errors++; $display("FAIL nickel_latency: got edge %0d expected %0d", hit_e, k + D + 3); end
        checks++; if (code != 1) begin errors++; $display("FAIL nickel_code: got %0d expected 1", code); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL nickel_pending: got %0d expected 0", pending); end
    endtask

    task automatic test_glitch();
        int r0 = rej_seen, m0 = emit_seen;
        pulse(2'b10, D - 1, 25);
        checks++; if (emit_seen != m0) begin errors++; $display("FAIL glitch_emit: got %0d codes expected 0", emit_seen - m0); end
        checks++; if (rej_seen != r0) begin errors++; $display("FAIL glitch_reject: got %0d pulses expected 0", rej_seen - r0); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL glitch_pending: got %0d expected 0", pending); end
    endtask

    task automatic test_sequence();
        int pos[$], codes[$];
        hold = 1'b1;
        pulse(2'b01, 8, 12);
        pulse(2'b10, 8, 12);
        pulse(2'b01, 8, 12);
        checks++; if (pending !== PW'(3)) begin errors++; $display("FAIL seq_pending: got %0d expected 3", pending); end
        checks++; if (money !== 2'b00) begin errors++; $display("FAIL seq_hold_money: got %0d expected 0", money); end
        hold = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (money !== 2'b00) begin pos.push_back(i); codes.push_back(int'(money)); end
        end
        checks++; if (codes.size() != 3) begin errors++; $display("FAIL seq_count: got %0d codes expected 3", codes.size()); end
        if (codes.size() == 3) begin
            checks++;
            if (codes[0] != 1 || codes[1] != 2 || codes[2] != 1) begin
                errors++; $display("FAIL seq_order: got %0d,%0d,%0d expected 1,2,1", codes[0], codes[1], codes[2]);
            end
            checks++; if (pos[0] != 0) begin errors++; $display("FAIL seq_first: got cycle %0d expected 0", pos[0]); end
            checks++; if (pos[1] - pos[0] != G + 1) begin errors++; $display("FAIL seq_gap1: got %0d expected %0d", pos[1] - pos[0], G + 1); end
            checks++; if (pos[2] - pos[1] != G + 1) begin errors++; $display("FAIL seq_gap2: got %0d expected %0d", pos[2] - pos[1], G + 1); end
        end
    endtask

    task automatic test_overflow();
        int r0 = rej_seen, m0;
        hold = 1'b1;
        for (int i = 0; i < 5; i++) pulse(i[0] ? 2'b10 : 2'b01, 8, 12);
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %0b expected 1", fifo_full); end
        checks++; if (pending !== PW'(DEPTH)) begin errors++; $display("FAIL ovf_pending: got %0d expected %0d", pending, DEPTH); end
        checks++; if (rej_seen - r0 != 1) begin errors++; $display("FAIL ovf_reject: got %0d pulses expected 1", rej_seen - r0); end
        m0 = emit_seen;
        hold = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (emit_seen - m0 != DEPTH) begin errors++; $display("FAIL ovf_emit: got %0d codes expected %0d", emit_seen - m0, DEPTH); end
        checks++; if (fifo_full !== 1'b0 || pending !== '0) begin errors++; $display("FAIL ovf_drain: got full=%0b pend=%0d expected 0/0", fifo_full, pending); end
    endtask

    task automatic test_simultaneous();
        int r0 = rej_seen, m0 = emit_seen;
        pulse(2'b11, 8, 14);
        checks++; if (rej_seen - r0 != 1) begin errors++; $display("FAIL simul_reject: got %0d pulses expected 1", rej_seen - r0); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL simul_pending: got %0d expected 0", pending); end
        checks++; if (emit_seen != m0) begin errors++; $display("FAIL simul_emit: got %0d codes expected 0", emit_seen - m0); end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int m0;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) pulse(i[0] ? 2'b10 : 2'b01, 8, 12);
        hold = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (money !== 2'b00) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rstmid_wait: got no code within 20 cycles expected one"); end
        checks++; if (pending !== PW'(2)) begin errors++; $display("FAIL rstmid_pre: got pending %0d expected 2", pending); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (money !== 2'b00) begin errors++; $display("FAIL rstmid_money: got %0d expected 0", money); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL rstmid_pending: got %0d expected 0", pending); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL rstmid_full: got %0b expected 0", fifo_full); end
        rst = 1'b0;
        m0 = emit_seen;
        repeat (30) @(negedge clk);
        checks++; if (emit_seen != m0) begin errors++; $display("FAIL rstmid_emit: got %0d codes expected 0", emit_seen - m0); end
    endtask

    task automatic test_random();
        int  rem[2];
        bit  lvl[2];
        rem[0] = 0; rem[1] = 0; lvl[0] = 0; lvl[1] = 0;
        for (int i = 0; i < 840; i++) begin
            @(negedge clk);
            checks++;
            if ({money, coin_reject, fifo_full, pending} !== {exp_money, exp_rej, exp_full, exp_pend}) begin
                errors++;
                $display("FAIL random cyc %0d: got money=%0d rej=%0b full=%0b pend=%0d expected money=%0d rej=%0b full=%0b pend=%0d",
                         i, money, coin_reject, fifo_full, pending, exp_money, exp_rej, exp_full, exp_pend);
            end
            if (i < 800) begin
                for (int c = 0; c < 2; c++) begin
                    if (rem[c] == 0) begin
                        lvl[c] = !lvl[c];
                        if (lvl[c]) rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D - 1))
                                                                         : int'($urandom_range(D + 2, D + 6));
                        else        rem[c] = int'($urandom_range(D + 2, D + 10));
                    end
                    rem[c]--;
                end
                nickel_in = lvl[0];
                dime_in   = lvl[1];
                if ($urandom_range(0, 9) == 0) hold = !hold;
            end else begin
                nickel_in = 1'b0;
                dime_in   = 1'b0;
                hold      = 1'b0;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nickel();
        test_glitch();
        test_sequence();
        test_overflow();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
